btn_debounce: RTL

Button conditioning stage placed directly upstream of the LED shift/counter logic. It synchronises a raw push-button input, applies a polarity inversion, and rejects bounce. It then emits clean single-cycle events: press, release, long-press and auto-repeat. Downstream blocks use these events as step, reset or advance strobes instead of sampling the pin directly.

---
 rtl/btn_debounce.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - push-button synchroniser, debouncer and press/release/long/repeat event generator
// One shared counter times debounce, long-press and repeat intervals; every output is a flop.
module btn_debounce #(
  parameter bit INV_BTN         = 1'b0,
  parameter int DEBOUNCE_CYCLES = 240_000,
  parameter int LONG_CYCLES     = 12_000_000,
  parameter int REPEAT_CYCLES   = 3_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic repeat_o
);

  localparam int MAX_DL = (DEBOUNCE_CYCLES > LONG_CYCLES) ? DEBOUNCE_CYCLES : LONG_CYCLES;
  localparam int MAX_N  = (MAX_DL > REPEAT_CYCLES) ? MAX_DL : REPEAT_CYCLES;
  localparam int CNT_W  = (MAX_N > 1) ? $clog2(MAX_N) : 1;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS_WAIT,
    S_HELD,
    S_LONG,
    S_RELEASE_WAIT
  } state_t;

  logic             btn_d;
  logic             sync1_q;
  logic             btn_s_q;
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             was_long_q;
  logic             level_q;
  logic             press_q;
  logic             release_q;
  logic             long_q;
  logic             repeat_q;

  assign btn_d = btn_i ^ INV_BTN;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      btn_s_q <= 1'b0;
    end else begin
      sync1_q <= btn_d;
      btn_s_q <= sync1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      was_long_q <= 1'b0;
      level_q    <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
      repeat_q   <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      // level stays high through the release pulse and drops the cycle after it
      if (release_q) begin
        level_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (btn_s_q) begin
            state_q <= S_PRESS_WAIT;
            cnt_q   <= '0;
          end
        end
        S_PRESS_WAIT: begin
          if (!btn_s_q) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == DEB_LAST) begin
            state_q <= S_HELD;
            cnt_q   <= '0;
            press_q <= 1'b1;
            level_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_HELD: begin
          if (!btn_s_q) begin
            state_q    <= S_RELEASE_WAIT;
            cnt_q      <= '0;
            was_long_q <= 1'b0;
          end else if (cnt_q == LONG_LAST) begin
            state_q  <= S_LONG;
            cnt_q    <= '0;
            long_q   <= 1'b1;
            repeat_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_LONG: begin
          if (!btn_s_q) begin
            state_q    <= S_RELEASE_WAIT;
            cnt_q      <= '0;
            was_long_q <= 1'b1;
          end else if (cnt_q == REP_LAST) begin
            cnt_q    <= '0;
            repeat_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_RELEASE_WAIT: begin
          // a release bounce resumes the previous held phase with a fresh timer
          if (btn_s_q) begin
            state_q <= was_long_q ? S_LONG : S_HELD;
            cnt_q   <= '0;
          end else if (cnt_q == DEB_LAST) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            release_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;
  assign repeat_o  = repeat_q;

endmodule
